// File: rtl/register_file_if.sv
// Decoder / ALU bus of the RV32I write-back register file.
// master = decoder+ALU side, slave = register file.
interface register_file_if #(
  parameter int XLEN = 32
);
  logic            read_enable;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            flush;
  logic            write_req;
  logic [4:0]      write_addr;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] src1_value;
  logic [XLEN-1:0] src2_value;
  logic            src_valid;
  logic            stall;

  modport master (
    output read_enable, rs1_addr, rs2_addr, issue_valid, issue_rd, flush,
           write_req, write_addr, write_data,
    input  src1_value, src2_value, src_valid, stall
  );

  modport slave (
    input  read_enable, rs1_addr, rs2_addr, issue_valid, issue_rd, flush,
           write_req, write_addr, write_data,
    output src1_value, src2_value, src_valid, stall
  );
endinterface

// File: rtl/register_file.sv
// RV32I register file x1..x31 with busy scoreboard and two registered read ports.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module register_file #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  register_file_if.slave bus
);

  logic [XLEN-1:0] regs_r [1:31];
  logic [31:0]     busy_r;
  logic [31:0]     busy_nxt_s;
  logic [31:0]     set_vec_s;
  logic [31:0]     clr_vec_s;
  logic [XLEN-1:0] stored1_s;
  logic [XLEN-1:0] stored2_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic [XLEN-1:0] src1_r;
  logic [XLEN-1:0] src2_r;
  logic            src_valid_r;
  logic            stall1_s;
  logic            stall2_s;
  logic            stall_s;
  logic            accept_s;
`ifdef REGFILE_BYPASS_EN
  logic            hit1_s;
  logic            hit2_s;
`endif

  // Stored-contents lookup; x0 is not in the array and falls back to zero
  always_comb begin
    stored1_s = {XLEN{1'b0}};
    stored2_s = {XLEN{1'b0}};
    for (int i = 1; i < 32; i++) begin
      stored1_s = (bus.rs1_addr == 5'(i)) ? regs_r[i] : stored1_s;
      stored2_s = (bus.rs2_addr == 5'(i)) ? regs_r[i] : stored2_s;
    end
  end

  // Operand selection and per-operand stall
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    hit1_s   = bus.write_req && (bus.write_addr == bus.rs1_addr) && (bus.rs1_addr != 5'd0);
    hit2_s   = bus.write_req && (bus.write_addr == bus.rs2_addr) && (bus.rs2_addr != 5'd0);
    rd1_s    = hit1_s ? bus.write_data : stored1_s;
    rd2_s    = hit2_s ? bus.write_data : stored2_s;
    stall1_s = bus.read_enable && busy_r[bus.rs1_addr] && !hit1_s;
    stall2_s = bus.read_enable && busy_r[bus.rs2_addr] && !hit2_s;
`else
    rd1_s    = stored1_s;
    rd2_s    = stored2_s;
    stall1_s = bus.read_enable && busy_r[bus.rs1_addr];
    stall2_s = bus.read_enable && busy_r[bus.rs2_addr];
`endif
    stall_s  = stall1_s || stall2_s;
    accept_s = bus.read_enable && !stall_s;
  end

  // Scoreboard next state: a new producer (set) beats both write-back clear and flush
  always_comb begin
    set_vec_s  = (bus.issue_valid && (bus.issue_rd != 5'd0)) ? (32'd1 << bus.issue_rd) : 32'd0;
    clr_vec_s  = (bus.write_req && (bus.write_addr != 5'd0)) ? (32'd1 << bus.write_addr) : 32'd0;
    if (bus.flush) begin
      busy_nxt_s = set_vec_s;
    end else begin
      busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Register storage write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (bus.write_req && (bus.write_addr == 5'(i))) begin
          regs_r[i] <= bus.write_data;
        end
      end
    end
  end

  // Busy bits and registered read ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r      <= 32'd0;
      src1_r      <= {XLEN{1'b0}};
      src2_r      <= {XLEN{1'b0}};
      src_valid_r <= 1'b0;
    end else begin
      busy_r      <= busy_nxt_s;
      src_valid_r <= accept_s;
      if (accept_s) begin
        src1_r <= rd1_s;
        src2_r <= rd2_s;
      end
    end
  end

  assign bus.src1_value = src1_r;
  assign bus.src2_value = src2_r;
  assign bus.src_valid  = src_valid_r;
  assign bus.stall      = stall_s;

endmodule
